pred_setp_pipe: RTL and testbench

- Two-stage EX→WB pipeline for SETP instructions in the CUDA-like SM core, one instance per thread lane.
- Accepts decoded SETP operands from ID and evaluates the compare in EX.
- Drives the predicate register file write port (sel/data/en) from WB.
- Exports a per-predicate pending scoreboard so ID can stall SELP/PBRA on predicates still in flight.

---
 rtl/pred_setp_pipe.sv | 129 ++++++++++++
 tb/tb_pred_setp_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_setp_pipe.sv
// Two-stage EX->WB SETP pipeline: predicate compare, pred-regfile write port and pending scoreboard.
// Optional retirement counters are enabled with `define SETP_PERF_EN.
module pred_setp_pipe #(
    parameter int DATA_W = 16,
    parameter int NPRED  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic                     id_active,
    input  logic [2:0]               id_cmp_op,
    input  logic [DATA_W-1:0]        id_src_a,
    input  logic [DATA_W-1:0]        id_src_b,
    input  logic [$clog2(NPRED)-1:0] id_pred_dst,
    input  logic                     stall,
    input  logic                     flush,
    output logic [$clog2(NPRED)-1:0] pred_write_sel,
    output logic                     pred_write_data,
    output logic                     pred_write_en,
    output logic [NPRED-1:0]         pred_busy
`ifdef SETP_PERF_EN
    ,
    output logic [15:0]              perf_setp_retired,
    output logic [15:0]              perf_setp_true
`endif
);

    localparam int SEL_W = $clog2(NPRED);

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_NE  = 3'd1;
    localparam logic [2:0] OP_LT  = 3'd2;
    localparam logic [2:0] OP_LE  = 3'd3;
    localparam logic [2:0] OP_GT  = 3'd4;
    localparam logic [2:0] OP_GE  = 3'd5;
    localparam logic [2:0] OP_LTU = 3'd6;
    localparam logic [2:0] OP_GEU = 3'd7;

    logic              r_ex_valid;
    logic              r_ex_active;
    logic [2:0]        r_ex_op;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [SEL_W-1:0]  r_ex_dst;

    logic              r_wb_valid;
    logic              r_wb_active;
    logic [SEL_W-1:0]  r_wb_dst;
    logic              r_wb_result;

    logic              w_cmp_result;
    logic              w_wr_en;

    // Stall freezes both stages; flush only matters when the pipe is moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_active <= 1'b0;
            r_ex_op     <= '0;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_ex_dst    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_active <= 1'b0;
            r_wb_dst    <= '0;
            r_wb_result <= 1'b0;
        end else if (!stall) begin
            r_ex_valid  <= id_valid & ~flush;
            r_ex_active <= id_active;
            r_ex_op     <= id_cmp_op;
            r_ex_a      <= id_src_a;
            r_ex_b      <= id_src_b;
            r_ex_dst    <= id_pred_dst;
            r_wb_valid  <= r_ex_valid & ~flush;
            r_wb_active <= r_ex_active;
            r_wb_dst    <= r_ex_dst;
            r_wb_result <= w_cmp_result;
        end
    end

    always_comb begin
        w_cmp_result = 1'b0;
        case (r_ex_op)
            OP_EQ:   w_cmp_result = (r_ex_a == r_ex_b);
            OP_NE:   w_cmp_result = (r_ex_a != r_ex_b);
            OP_LT:   w_cmp_result = ($signed(r_ex_a) <  $signed(r_ex_b));
            OP_LE:   w_cmp_result = ($signed(r_ex_a) <= $signed(r_ex_b));
            OP_GT:   w_cmp_result = ($signed(r_ex_a) >  $signed(r_ex_b));
            OP_GE:   w_cmp_result = ($signed(r_ex_a) >= $signed(r_ex_b));
            OP_LTU:  w_cmp_result = (r_ex_a <  r_ex_b);
            OP_GEU:  w_cmp_result = (r_ex_a >= r_ex_b);
            default: w_cmp_result = 1'b0;
        endcase
    end

    assign w_wr_en         = r_wb_valid & r_wb_active;
    assign pred_write_en   = w_wr_en;
    assign pred_write_sel  = w_wr_en ? r_wb_dst : '0;
    assign pred_write_data = w_wr_en & r_wb_result;

    // Inactive lanes travel the pipe as placeholders but never claim a predicate.
    always_comb begin
        pred_busy = '0;
        for (int p = 0; p < NPRED; p++) begin
            pred_busy[p] = (r_ex_valid & r_ex_active & (r_ex_dst == SEL_W'(p)))
                         | (r_wb_valid & r_wb_active & (r_wb_dst == SEL_W'(p)));
        end
    end

`ifdef SETP_PERF_EN
    logic [15:0] r_perf_retired;
    logic [15:0] r_perf_true;

    // Repeated writes under stall are counted once, on the cycle the entry leaves WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_true    <= '0;
        end else if (w_wr_en && !stall) begin
            r_perf_retired <= r_perf_retired + 16'd1;
            if (r_wb_result) r_perf_true <= r_perf_true + 16'd1;
        end
    end

    assign perf_setp_retired = r_perf_retired;
    assign perf_setp_true    = r_perf_true;
`endif

endmodule

// File: tb/tb_pred_setp_pipe.sv
// Bench for pred_setp_pipe: directed scenarios plus randomized traffic against an in-flight queue model.
module tb_pred_setp_pipe;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_active;
  logic [2:0]  id_cmp_op;
  logic [15:0] id_src_a;
  logic [15:0] id_src_b;
  logic [1:0]  id_pred_dst;
  logic        stall;
  logic        flush;
  logic [1:0]  pred_write_sel;
  logic        pred_write_data;
  logic        pred_write_en;
  logic [3:0]  pred_busy;
`ifdef SETP_PERF_EN
  logic [15:0] perf_setp_retired;
  logic [15:0] perf_setp_true;
`endif

  int checks;
  int failures;

  pred_setp_pipe #(.DATA_W(16), .NPRED(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_active       (id_active),
    .id_cmp_op       (id_cmp_op),
    .id_src_a        (id_src_a),
    .id_src_b        (id_src_b),
    .id_pred_dst     (id_pred_dst),
    .stall           (stall),
    .flush           (flush),
    .pred_write_sel  (pred_write_sel),
    .pred_write_data (pred_write_data),
    .pred_write_en   (pred_write_en),
    .pred_busy       (pred_busy)
`ifdef SETP_PERF_EN
    ,
    .perf_setp_retired (perf_setp_retired),
    .perf_setp_true    (perf_setp_true)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: queue of in-flight SETPs, index 0 is the one currently writing
  typedef struct {
    logic       v;
    logic       act;
    logic [1:0] dst;
    logic       res;
  } ent_t;

  ent_t        pipe_q[$];
  logic [15:0] m_retired;
  logic [15:0] m_true;

  function automatic logic ref_cmp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    case (op)
      3'd0:    return ua == ub;
      3'd1:    return ua != ub;
      3'd2:    return sa <  sb;
      3'd3:    return sa <= sb;
      3'd4:    return sa >  sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua <  ub;
      default: return ua >= ub;
    endcase
  endfunction

  task automatic model_clear();
    ent_t bubble;
    bubble = '{v: 1'b0, act: 1'b0, dst: 2'd0, res: 1'b0};
    pipe_q.delete();
    pipe_q.push_back(bubble);
    pipe_q.push_back(bubble);
  endtask

  task automatic model_edge();
    ent_t nw;
    if (rst) begin
      model_clear();
      m_retired = '0;
      m_true    = '0;
    end else if (!stall) begin
      if (pipe_q[0].v && pipe_q[0].act) begin
        m_retired = m_retired + 16'd1;
        if (pipe_q[0].res) m_true = m_true + 16'd1;
      end
      if (flush) pipe_q[1].v = 1'b0;
      void'(pipe_q.pop_front());
      nw.v   = id_valid && !flush;
      nw.act = id_active;
      nw.dst = id_pred_dst;
      nw.res = ref_cmp(id_cmp_op, id_src_a, id_src_b);
      pipe_q.push_back(nw);
    end
  endtask

  task automatic check_model();
    logic       e_we;
    logic [3:0] e_busy;
    e_we   = pipe_q[0].v && pipe_q[0].act;
    e_busy = '0;
    foreach (pipe_q[i]) if (pipe_q[i].v && pipe_q[i].act) e_busy[pipe_q[i].dst] = 1'b1;
    check_val("write_en",   32'(pred_write_en),   32'(e_we));
    check_val("write_sel",  32'(pred_write_sel),  e_we ? 32'(pipe_q[0].dst) : 32'd0);
    check_val("write_data", 32'(pred_write_data), 32'(e_we && pipe_q[0].res));
    check_val("busy",       32'(pred_busy),       32'(e_busy));
`ifdef SETP_PERF_EN
    check_val("perf_retired", 32'(perf_setp_retired), 32'(m_retired));
    check_val("perf_true",    32'(perf_setp_true),    32'(m_true));
`endif
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] dst, input logic act);
    id_valid    = 1'b1;
    id_active   = act;
    id_cmp_op   = op;
    id_src_a    = a;
    id_src_b    = b;
    id_pred_dst = dst;
  endtask

  task automatic idle();
    id_valid = 1'b0;
  endtask

  task automatic expect_port(input string tag, input logic we, input logic [1:0] sel,
                             input logic data, input logic [3:0] busy);
    check_val({tag, "_we"},   32'(pred_write_en),   32'(we));
    check_val({tag, "_sel"},  32'(pred_write_sel),  32'(sel));
    check_val({tag, "_data"}, 32'(pred_write_data), 32'(data));
    check_val({tag, "_busy"}, 32'(pred_busy),       32'(busy));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_retired = '0;
    m_true = '0;
    model_clear();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_active = 1'b0; id_cmp_op = '0;
    id_src_a = '0; id_src_b = '0; id_pred_dst = '0;
    tick(); tick();
    expect_port("reset", 1'b0, 2'd0, 1'b0, 4'b0000);
    rst = 1'b0;

    // signed LT: -1 < 1 is true
    issue(3'd2, 16'hFFFF, 16'h0001, 2'd1, 1'b1); tick();
    expect_port("lt_ex", 1'b0, 2'd0, 1'b0, 4'b0010);
    idle(); tick();
    expect_port("lt_wb", 1'b1, 2'd1, 1'b1, 4'b0010);
    tick();
    expect_port("lt_done", 1'b0, 2'd0, 1'b0, 4'b0000);

    // unsigned LTU: 0xFFFF < 1 is false
    issue(3'd6, 16'hFFFF, 16'h0001, 2'd1, 1'b1); tick();
    idle(); tick();
    expect_port("ltu_wb", 1'b1, 2'd1, 1'b0, 4'b0010);
    tick();

    // back-to-back
    issue(3'd0, 16'd5, 16'd5, 2'd0, 1'b1); tick();
    issue(3'd5, 16'd3, 16'd7, 2'd2, 1'b1); tick();
    expect_port("b2b_1", 1'b1, 2'd0, 1'b1, 4'b0101);
    issue(3'd1, 16'd4, 16'd4, 2'd3, 1'b1); tick();
    expect_port("b2b_2", 1'b1, 2'd2, 1'b0, 4'b1100);
    idle(); tick();
    expect_port("b2b_3", 1'b1, 2'd3, 1'b0, 4'b1000);
    tick();
    expect_port("b2b_end", 1'b0, 2'd0, 1'b0, 4'b0000);

    // flush kills EX, WB still retires
    issue(3'd2, 16'd1, 16'd2, 2'd1, 1'b1); tick();
    issue(3'd0, 16'd8, 16'd8, 2'd2, 1'b1); tick();
    expect_port("fl_pre", 1'b1, 2'd1, 1'b1, 4'b0110);
    issue(3'd0, 16'd1, 16'd1, 2'd3, 1'b1); flush = 1'b1; tick();
    expect_port("fl_post", 1'b0, 2'd0, 1'b0, 4'b0000);
    flush = 1'b0; idle(); tick();
    expect_port("fl_nowr", 1'b0, 2'd0, 1'b0, 4'b0000);

    // stall holds both stages and ignores new issue
    issue(3'd0, 16'd1, 16'd1, 2'd0, 1'b1); tick();
    issue(3'd6, 16'd1, 16'd2, 2'd3, 1'b1); tick();
    issue(3'd0, 16'd0, 16'd0, 2'd1, 1'b1); stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_port("stall", 1'b1, 2'd0, 1'b1, 4'b1001);
    end
    stall = 1'b0; flush = 1'b0; idle(); tick();
    expect_port("unstall", 1'b1, 2'd3, 1'b1, 4'b1000);
    tick();
    expect_port("unstall_end", 1'b0, 2'd0, 1'b0, 4'b0000);

    // inactive lane
    issue(3'd0, 16'd9, 16'd9, 2'd1, 1'b0); tick();
    expect_port("inact_ex", 1'b0, 2'd0, 1'b0, 4'b0000);
    idle(); tick();
    expect_port("inact_wb", 1'b0, 2'd0, 1'b0, 4'b0000);

    // reset mid-flight
    issue(3'd0, 16'd2, 16'd2, 2'd0, 1'b1); tick();
    issue(3'd0, 16'd3, 16'd3, 2'd1, 1'b1); tick();
    rst = 1'b1; idle(); tick();
    expect_port("rst_mid", 1'b0, 2'd0, 1'b0, 4'b0000);
    rst = 1'b0; tick();
    expect_port("rst_after", 1'b0, 2'd0, 1'b0, 4'b0000);

`ifdef SETP_PERF_EN
    issue(3'd2, 16'hFFFF, 16'h0001, 2'd0, 1'b1); tick();
    issue(3'd0, 16'd5, 16'd5, 2'd1, 1'b1); tick();
    issue(3'd1, 16'd4, 16'd4, 2'd2, 1'b1); tick();
    idle(); tick(); tick();
    check_val("perf_ret_3",  32'(perf_setp_retired), 32'd3);
    check_val("perf_true_2", 32'(perf_setp_true),    32'd2);
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_active   = ($urandom_range(0, 4) != 0);
      id_cmp_op   = 3'($urandom_range(0, 7));
      id_src_a    = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      id_src_b    = ($urandom_range(0, 3) == 0) ? id_src_a : 16'($urandom);
      id_pred_dst = 2'($urandom_range(0, 3));
      stall       = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
